hpm_counter_bank: RTL and testbench

Parametrised bank of machine hardware performance-monitor counters (mhpmcounter3..3+N-1) with per-counter event selectors, inhibit control and an optional overflow interrupt. It sits beside the CSR unit: the CSR unit forwards counter-range CSR accesses here, and pipeline stages drive one-cycle event pulses. It generalises the fixed HPM address map in the shared types package to a configurable counter count, counter width and event count.

---
 rtl/hpm_counter_bank_pkg.sv | 64 ++++++
 rtl/hpm_counter_bank_if.sv | 15 +
 rtl/hpm_counter_bank_counter.sv | 71 +++++++
 rtl/hpm_counter_bank.sv | 102 ++++++++++
 tb/tb_hpm_counter_bank.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/hpm_counter_bank_pkg.sv
// Shared HPM types: CSR address map, event-config struct and address decode helpers.
package hpm_counter_bank_pkg;

  localparam int HPM_FIRST_IDX    = 3;
  localparam int HPM_MAX_COUNTERS = 29;
  localparam int HPM_SEL_MAX_W    = 6;

  typedef enum logic [11:0] {
    CSR_MCOUNTINHIBIT  = 12'h320,
    CSR_MHPMEVENT3     = 12'h323,
    CSR_MHPMEVENT3H    = 12'h723,
    CSR_MHPMCOUNTER3   = 12'hB03,
    CSR_MHPMCOUNTER3H  = 12'hB83,
    CSR_HPMCOUNTER3    = 12'hC03,
    CSR_HPMCOUNTER3H   = 12'hC83
  } csr_reg_addr_t;

  localparam logic [11:0] HPM_CNT_LO_BASE = CSR_MHPMCOUNTER3;
  localparam logic [11:0] HPM_CNT_HI_BASE = CSR_MHPMCOUNTER3H;
  localparam logic [11:0] HPM_SHD_LO_BASE = CSR_HPMCOUNTER3;
  localparam logic [11:0] HPM_SHD_HI_BASE = CSR_HPMCOUNTER3H;
  localparam logic [11:0] HPM_EVT_BASE    = CSR_MHPMEVENT3;
  localparam logic [11:0] HPM_EVT_H_BASE  = CSR_MHPMEVENT3H;
  localparam logic [11:0] HPM_INHIBIT     = CSR_MCOUNTINHIBIT;

  // Selector is zero-extended to the widest legal selector (63 events).
  typedef struct packed {
    logic                     of;
    logic [HPM_SEL_MAX_W-1:0] sel;
  } hpm_event_cfg_t;

  typedef enum logic [2:0] {
    REG_NONE, REG_CNT_LO, REG_CNT_HI, REG_SHD_LO,
    REG_SHD_HI, REG_EVT, REG_EVT_H, REG_INHIBIT
  } hpm_region_e;

  function automatic logic in_window(input logic [11:0] addr, input logic [11:0] base);
    return (addr >= base) && (addr < base + 12'(HPM_MAX_COUNTERS));
  endfunction

  function automatic hpm_region_e decode_region(input logic [11:0] addr);
    if (addr == HPM_INHIBIT)                 return REG_INHIBIT;
    if (in_window(addr, HPM_CNT_LO_BASE))    return REG_CNT_LO;
    if (in_window(addr, HPM_CNT_HI_BASE))    return REG_CNT_HI;
    if (in_window(addr, HPM_SHD_LO_BASE))    return REG_SHD_LO;
    if (in_window(addr, HPM_SHD_HI_BASE))    return REG_SHD_HI;
    if (in_window(addr, HPM_EVT_BASE))       return REG_EVT;
    if (in_window(addr, HPM_EVT_H_BASE))     return REG_EVT_H;
    return REG_NONE;
  endfunction

  function automatic logic [11:0] region_base(input hpm_region_e r);
    case (r)
      REG_CNT_LO: return HPM_CNT_LO_BASE;
      REG_CNT_HI: return HPM_CNT_HI_BASE;
      REG_SHD_LO: return HPM_SHD_LO_BASE;
      REG_SHD_HI: return HPM_SHD_HI_BASE;
      REG_EVT:    return HPM_EVT_BASE;
      REG_EVT_H:  return HPM_EVT_H_BASE;
      default:    return HPM_INHIBIT;
    endcase
  endfunction

endpackage

// File: rtl/hpm_counter_bank_if.sv
// CSR access channel between the CSR unit (master) and the HPM bank (slave).
interface hpm_csr_if;
  logic        csr_re;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_rvalid;
  logic        csr_hit;
  logic [31:0] csr_rdata;

  modport master (output csr_re, csr_we, csr_addr, csr_wdata,
                  input  csr_rvalid, csr_hit, csr_rdata);
  modport slave  (input  csr_re, csr_we, csr_addr, csr_wdata,
                  output csr_rvalid, csr_hit, csr_rdata);
endinterface

// File: rtl/hpm_counter_bank_counter.sv
// One HPM counter: count register, WARL event selector and optional OF bit.
// OF storage exists only when HPM_OVERFLOW_IRQ_EN is defined.
module hpm_counter
  import hpm_counter_bank_pkg::*;
#(
  parameter int COUNTER_W  = 64,
  parameter int NUM_EVENTS = 16,
  parameter int SEL_W      = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_EVENTS-1:0] events,
  input  logic                  inhibit,
  input  logic                  we_lo,
  input  logic                  we_hi,
  input  logic                  we_sel,
  input  logic                  we_of,
  input  logic [31:0]           wdata,
  output logic [31:0]           cnt_lo,
  output logic [31:0]           cnt_hi,
  output hpm_event_cfg_t        cfg
);

  logic [COUNTER_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]     sel_q;
  logic [NUM_EVENTS:0]  ev_ext;
  logic                 incr;
  logic                 of_q;

  // Selector 0 lands on the padding bit, so it never counts.
  assign ev_ext = {events, 1'b0};
  assign incr   = ev_ext[sel_q] && !inhibit && !we_lo && !we_hi;

  // Next count: a CSR write to either word suppresses that cycle's increment.
  always_comb begin
    cnt_d = cnt_q;
    if (we_lo) cnt_d[31:0] = wdata;
    if (we_hi) cnt_d[COUNTER_W-1:32] = wdata[COUNTER_W-33:0];
    if (incr)  cnt_d = cnt_q + COUNTER_W'(1);
  end

  // Counter and selector state; out-of-range selector writes store 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (we_sel) sel_q <= (wdata <= 32'(NUM_EVENTS)) ? SEL_W'(wdata) : '0;
    end
  end

`ifdef HPM_OVERFLOW_IRQ_EN
  // OF latches on an increment-driven wrap; a software write in the same cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              of_q <= 1'b0;
    else if (we_of)          of_q <= wdata[31];
    else if (incr && &cnt_q) of_q <= 1'b1;
  end
`else
  logic unused_we_of;
  assign unused_we_of = we_of;
  assign of_q = 1'b0;
`endif

  assign cnt_lo  = cnt_q[31:0];
  assign cnt_hi  = 32'(cnt_q[COUNTER_W-1:32]);
  assign cfg.of  = of_q;
  assign cfg.sel = HPM_SEL_MAX_W'(sel_q);

endmodule

// File: rtl/hpm_counter_bank.sv
// HPM counter bank: decode, inhibit register, registered read path, interrupt OR.
// Optional feature macro: HPM_OVERFLOW_IRQ_EN (counter-overflow OF bits and irq).
module hpm_counter_bank
  import hpm_counter_bank_pkg::*;
#(
  parameter int NUM_COUNTERS = 4,
  parameter int COUNTER_W    = 64,
  parameter int NUM_EVENTS   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_EVENTS-1:0] events,
  hpm_csr_if.slave              csr,
  output logic                  overflow_irq
);

  hpm_region_e             region;
  logic [4:0]              idx;
  logic                    rd_hit, wr_hit;
  logic [31:0]             rd_val;
  logic [NUM_COUNTERS-1:0] inhibit_q;
  logic [NUM_COUNTERS-1:0] of_vec;
  logic [31:0]             cnt_lo [NUM_COUNTERS];
  logic [31:0]             cnt_hi [NUM_COUNTERS];
  hpm_event_cfg_t          cfg    [NUM_COUNTERS];

  // Address decode: region plus counter index within the 29-entry window.
  always_comb begin
    region = decode_region(csr.csr_addr);
    idx    = 5'(csr.csr_addr - region_base(region));
    rd_hit = (region != REG_NONE);
    wr_hit = rd_hit && (region != REG_SHD_LO) && (region != REG_SHD_HI);
  end

  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cnt
    logic sel_me;
    assign sel_me = csr.csr_we && (idx == 5'(i));

    hpm_counter #(
      .COUNTER_W (COUNTER_W),
      .NUM_EVENTS(NUM_EVENTS)
    ) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .events (events),
      .inhibit(inhibit_q[i]),
      .we_lo  (sel_me && region == REG_CNT_LO),
      .we_hi  (sel_me && region == REG_CNT_HI),
      .we_sel (sel_me && region == REG_EVT),
      .we_of  (sel_me && region == REG_EVT_H),
      .wdata  (csr.csr_wdata),
      .cnt_lo (cnt_lo[i]),
      .cnt_hi (cnt_hi[i]),
      .cfg    (cfg[i])
    );

    assign of_vec[i] = cfg[i].of;
  end

  // Read mux over current (pre-write) state; unimplemented indices read 0.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (idx == 5'(i)) begin
        case (region)
          REG_CNT_LO, REG_SHD_LO: rd_val = cnt_lo[i];
          REG_CNT_HI, REG_SHD_HI: rd_val = cnt_hi[i];
          REG_EVT:                rd_val = 32'(cfg[i].sel);
          REG_EVT_H:              rd_val = {cfg[i].of, 31'b0};
          default:                ;
        endcase
      end
    end
    if (region == REG_INHIBIT) rd_val = 32'(inhibit_q) << HPM_FIRST_IDX;
  end

  // Inhibit bits live at mcountinhibit[3 +: NUM_COUNTERS]; the rest read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  inhibit_q <= '0;
    else if (csr.csr_we && region == REG_INHIBIT) inhibit_q <= csr.csr_wdata[HPM_FIRST_IDX +: NUM_COUNTERS];
  end

  // Registered response; a write-only access reports its hit (low for shadows).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csr.csr_rvalid <= 1'b0;
      csr.csr_hit    <= 1'b0;
      csr.csr_rdata  <= '0;
    end else begin
      csr.csr_rvalid <= csr.csr_re;
      csr.csr_hit    <= csr.csr_re ? rd_hit : (csr.csr_we && wr_hit);
      csr.csr_rdata  <= (csr.csr_re && rd_hit) ? rd_val : '0;
    end
  end

  // Level interrupt: registered OR of all OF bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_irq <= 1'b0;
    else        overflow_irq <= |of_vec;
  end

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Directed bench for hpm_counter_bank (NUM_COUNTERS=4, COUNTER_W=64, NUM_EVENTS=16).
module tb_hpm_counter_bank;

  localparam int NC = 4;
  localparam int CW = 64;
  localparam int NE = 16;

`ifdef HPM_OVERFLOW_IRQ_EN
  localparam logic        EXP_IRQ = 1'b1;
  localparam logic [31:0] EXP_OF  = 32'h8000_0000;
`else
  localparam logic        EXP_IRQ = 1'b0;
  localparam logic [31:0] EXP_OF  = 32'h0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NE-1:0] events = '0;
  logic          overflow_irq;
  int            checks = 0;
  int            failures = 0;

  hpm_csr_if csr_if ();

  hpm_counter_bank #(
    .NUM_COUNTERS(NC),
    .COUNTER_W   (CW),
    .NUM_EVENTS  (NE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .events      (events),
    .csr         (csr_if),
    .overflow_irq(overflow_irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_if.csr_we = 1'b1; csr_if.csr_addr = a; csr_if.csr_wdata = d;
    @(negedge clk);
    csr_if.csr_we = 1'b0;
  endtask

  task automatic csr_rd(input string tag, input logic [11:0] a, input logic exp_hit, input logic [31:0] exp_data);
    @(negedge clk);
    csr_if.csr_re = 1'b1; csr_if.csr_addr = a;
    @(negedge clk);
    csr_if.csr_re = 1'b0;
    check_eq({tag, " rvalid"}, 64'(csr_if.csr_rvalid), 64'd1);
    check_eq({tag, " hit"}, 64'(csr_if.csr_hit), 64'(exp_hit));
    check_eq({tag, " data"}, 64'(csr_if.csr_rdata), 64'(exp_data));
  endtask

  task automatic pulse(input int k, input int n);
    @(negedge clk);
    events = NE'(1) << (k - 1);
    repeat (n) @(negedge clk);
    events = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    csr_if.csr_re = 1'b0; csr_if.csr_we = 1'b0;
    csr_if.csr_addr = '0; csr_if.csr_wdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst rvalid", 64'(csr_if.csr_rvalid), 64'd0);
    check_eq("rst hit", 64'(csr_if.csr_hit), 64'd0);
    check_eq("rst rdata", 64'(csr_if.csr_rdata), 64'd0);
    check_eq("rst irq", 64'(overflow_irq), 64'd0);

    // counter 3 counts events[1]
    csr_wr(12'h323, 32'd2);
    csr_rd("sel3", 12'h323, 1'b1, 32'd2);
    pulse(2, 5);
    csr_rd("cnt3 five", 12'hB03, 1'b1, 32'd5);
    csr_rd("cnt4 zero", 12'hB04, 1'b1, 32'd0);

    // wrap at 2^64-1
    csr_wr(12'hB03, 32'hFFFF_FFFF);
    csr_wr(12'hB83, 32'hFFFF_FFFF);
    csr_rd("cnt3h ones", 12'hB83, 1'b1, 32'hFFFF_FFFF);
    @(negedge clk); events = NE'(2);
    @(negedge clk); events = '0;
    check_eq("irq not yet", 64'(overflow_irq), 64'd0);
    @(negedge clk);
    check_eq("irq after wrap", 64'(overflow_irq), 64'(EXP_IRQ));
    csr_rd("wrap lo", 12'hB03, 1'b1, 32'd0);
    csr_rd("wrap hi", 12'hB83, 1'b1, 32'd0);
    csr_rd("of bit", 12'h723, 1'b1, EXP_OF);
    csr_wr(12'h723, 32'd0);
    @(negedge clk);
    check_eq("irq cleared", 64'(overflow_irq), 64'd0);

    // write beats same-cycle increment
    @(negedge clk);
    csr_if.csr_we = 1'b1; csr_if.csr_addr = 12'hB03; csr_if.csr_wdata = 32'h10; events = NE'(2);
    @(negedge clk);
    csr_if.csr_we = 1'b0; events = '0;
    csr_rd("wr wins", 12'hB03, 1'b1, 32'h10);
    pulse(2, 1);
    csr_rd("inc resumes", 12'hB03, 1'b1, 32'h11);

    // WARL selector and inhibit
    csr_wr(12'h323, 32'd200);
    csr_rd("sel warl", 12'h323, 1'b1, 32'd0);
    csr_wr(12'h323, 32'd2);
    csr_wr(12'h320, 32'hFFFF_FFFF);
    csr_rd("inhibit rd", 12'h320, 1'b1, 32'h78);
    pulse(2, 3);
    csr_rd("inhibited", 12'hB03, 1'b1, 32'h11);
    csr_wr(12'h320, 32'd0);
    pulse(2, 1);
    csr_rd("uninhibited", 12'hB03, 1'b1, 32'h12);

    // hit behaviour
    csr_rd("unimpl", 12'hB07, 1'b1, 32'd0);
    @(negedge clk);
    csr_if.csr_we = 1'b1; csr_if.csr_addr = 12'hC03; csr_if.csr_wdata = 32'h55;
    @(negedge clk);
    csr_if.csr_we = 1'b0;
    check_eq("shadow wr hit", 64'(csr_if.csr_hit), 64'd0);
    csr_rd("shadow rd", 12'hC03, 1'b1, 32'h12);
    csr_rd("cnt3 kept", 12'hB03, 1'b1, 32'h12);
    csr_rd("out of map", 12'h7C0, 1'b0, 32'd0);

    // independent counter 4 on events[0]
    csr_wr(12'h324, 32'd1);
    pulse(1, 2);
    csr_rd("cnt4 two", 12'hB04, 1'b1, 32'd2);
    csr_rd("cnt3 still", 12'hB03, 1'b1, 32'h12);

    // read and write same address: old value returned
    @(negedge clk);
    csr_if.csr_re = 1'b1; csr_if.csr_we = 1'b1; csr_if.csr_addr = 12'hB03; csr_if.csr_wdata = 32'h99;
    @(negedge clk);
    csr_if.csr_re = 1'b0; csr_if.csr_we = 1'b0;
    check_eq("rw rvalid", 64'(csr_if.csr_rvalid), 64'd1);
    check_eq("rw old data", 64'(csr_if.csr_rdata), 64'h12);
    @(negedge clk);
    check_eq("rvalid one cycle", 64'(csr_if.csr_rvalid), 64'd0);
    csr_rd("rw new data", 12'hB03, 1'b1, 32'h99);

    // reset with read in flight
    @(negedge clk);
    csr_if.csr_re = 1'b1; csr_if.csr_addr = 12'hB03;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst rvalid drop", 64'(csr_if.csr_rvalid), 64'd0);
    check_eq("rst rdata drop", 64'(csr_if.csr_rdata), 64'd0);
    @(negedge clk);
    csr_if.csr_re = 1'b0;
    rst_n = 1'b1;
    csr_rd("post rst cnt3", 12'hB03, 1'b1, 32'd0);
    csr_rd("post rst cnt4", 12'hB04, 1'b1, 32'd0);
    csr_rd("post rst sel3", 12'h323, 1'b1, 32'd0);
    csr_rd("post rst sel4", 12'h324, 1'b1, 32'd0);
    check_eq("post rst irq", 64'(overflow_irq), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
